fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the instruction decoder/controller.
- Holds the PC, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register that the decoder consumes.
- Applies redirects for j/jal (Jump) and jr (JumpReg) resolved in ID, flushing the wrong-path slot.
- Honours a load-use Stall from the hazard unit.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on Reset.
- NOP_WORD, 32'h00000000, bubble instruction written into IF/ID on reset and flush. Decodes as sll $0,$0,0, which is harmless because $0 is hardwired.

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- Jump  in  1  from controller (ID): j/jal in the ID slot.
- JumpReg  in  1  from controller (ID): jr in the ID slot.
- JrTarget  in  32  register-file read data 1 for jr.
- ImemData  in  32  instruction memory read data; combinational, same cycle as ImemAddr.
- ImemAddr  out  32  current PC, driven combinationally.
- IfId_Instruction  out  32  registered instruction to the decoder.
- IfId_PCPlus4  out  32  registered PC+4 of that instruction (used by jal link and jump target).
- IfId_Valid  out  1  IF/ID holds a real fetched instruction.
- FetchCount  out  32  number of instructions latched valid into IF/ID since reset.
- Misalign  out  1  sticky: a jr target had nonzero bits [1:0].

Behaviour:
- Clock and reset: all state updates on the rising edge of Clk. Reset is synchronous, active-high.
- Reset values: PC=RESET_PC, IfId_Instruction=NOP_WORD, IfId_PCPlus4=0, IfId_Valid=0, FetchCount=0, Misalign=0.
- Reset asserted mid-operation overrides every other input, including Stall and redirect.
- ImemAddr = PC at all times.
- Latency: the word at PC in cycle n appears on IfId_Instruction in cycle n+1.
- Redirect condition: redirect = (Jump | JumpReg) & IfId_Valid. Jump/JumpReg asserted while IfId_Valid=0 are ignored.
- Jump target: {IfId_PCPlus4[31:28], IfId_Instruction[25:0], 2'b00}.
- JumpReg target: {JrTarget[31:2], 2'b00}. If JrTarget[1:0] != 0, Misalign is set; it stays set until Reset.
- If Jump and JumpReg are both asserted, JumpReg wins.
- Per-cycle priority, highest first:
  1. Reset.
  2. Redirect: PC<=target; IfId_Instruction<=NOP_WORD; IfId_Valid<=0; IfId_PCPlus4<=0. The word fetched this cycle is discarded. Penalty is exactly one bubble.
  3. Stall: PC and all IF/ID registers hold. FetchCount holds.
  4. Normal: PC<=PC+4; IfId_Instruction<=ImemData; IfId_PCPlus4<=PC+4; IfId_Valid<=1; FetchCount<=FetchCount+1.
- Redirect beats Stall. The hazard unit never stalls on a jump, and this ordering guarantees forward progress.
- Width and wrap rules:
  - PC+4 is modulo 2^32; 32'hFFFFFFFC wraps to 0 with no flag.
  - FetchCount wraps modulo 2^32.
- Back-to-back redirects: the second jump cannot be in ID, because the slot after a redirect is always a bubble (IfId_Valid=0). No chained-redirect case exists.
- Next-state logic is purely a function of registered state and current inputs. There are no combinational paths from Stall/Jump/JumpReg to ImemAddr.

Decomposition:
- Package fetch_pkg:
  - PC_INC = 32'd4.
  - NOP_WORD default.
  - Opcode constants OP_J = 6'b000010 and OP_JAL = 6'b000011, shared with the decoder and benches.
- Sub-module if_id_reg: holds IfId_Instruction, IfId_PCPlus4 and IfId_Valid, with enable (~Stall) and flush (redirect) inputs. Next-PC selection stays in fetch_stage.

Test Plan:
- Reset, then 4 free-running cycles with ImemData = 32'h20080005 and no stall or redirect → ImemAddr steps 0, 4, 8, 12, 16; IfId_PCPlus4 = 4, 8, 12, 16; IfId_Valid = 1 from the 2nd cycle; FetchCount = 4.
- Stall high for 2 cycles at PC=8 → ImemAddr stays 8, IF/ID unchanged, FetchCount unchanged; fetch resumes at 8 → 12.
- IF/ID holds j (32'h08000010, PCPlus4=32'h00000008) with Jump=1 → next ImemAddr = 32'h00000040, IfId_Valid=0 and IfId_Instruction = NOP_WORD for one cycle, then the word at 0x40 is latched.
- JumpReg=1 with JrTarget = 32'h00000102 → ImemAddr = 32'h00000100, Misalign=1, and it remains 1 across later cycles until Reset.
- Jump and Stall asserted in the same cycle → redirect taken, bubble inserted; Jump=1 with IfId_Valid=0 → ignored, PC+4.
- Reset asserted mid-stall at PC = 32'hFFFFFFFC → next cycle PC = RESET_PC and all outputs at reset values. Without reset, PC 32'hFFFFFFFC wraps to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the MIPS instruction-fetch stage.
// The decoder and benches import the opcode values from here as well.
package fetch_pkg;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    // Source of the next PC, in decreasing priority order.
    typedef enum logic [1:0] {
        SEL_JR   = 2'd0,
        SEL_JUMP = 2'd1,
        SEL_HOLD = 2'd2,
        SEL_SEQ  = 2'd3
    } pc_sel_e;

    // The j/jal target keeps the upper PC nibble of the delay-free successor.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] instr);
        return {pc_plus4[31:28], instr[25:0], 2'b00};
    endfunction

    function automatic logic [31:0] jr_target(input logic [31:0] rs_data);
        return {rs_data[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage and its surroundings
// (hazard unit, controller, register file, instruction memory, decoder).
interface fetch_if;

    // Stall holds the PC and IF/ID for the cycle it is high; Jump/JumpReg
    // only take effect while IfId_Valid is high, and then override Stall.
    logic        Stall;
    logic        Jump;
    logic        JumpReg;
    logic [31:0] JrTarget;
    logic [31:0] ImemData;
    logic [31:0] ImemAddr;
    logic [31:0] IfId_Instruction;
    logic [31:0] IfId_PCPlus4;
    logic        IfId_Valid;
    logic [31:0] FetchCount;
    logic        Misalign;

    modport master (
        input  Stall,
        input  Jump,
        input  JumpReg,
        input  JrTarget,
        input  ImemData,
        output ImemAddr,
        output IfId_Instruction,
        output IfId_PCPlus4,
        output IfId_Valid,
        output FetchCount,
        output Misalign
    );

    modport slave (
        output Stall,
        output Jump,
        output JumpReg,
        output JrTarget,
        output ImemData,
        input  ImemAddr,
        input  IfId_Instruction,
        input  IfId_PCPlus4,
        input  IfId_Valid,
        input  FetchCount,
        input  Misalign
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble and beats enable,
// enable low holds the current contents.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            instr_d    = NOP_WORD;
            pc_plus4_d = 32'd0;
            valid_d    = 1'b0;
        end else if (en) begin
            instr_d    = instr_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            instr_q    <= NOP_WORD;
            pc_plus4_q <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, applies j/jal/jr redirects resolved
// in ID with a one-bubble penalty, and honours load-use stalls.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic   Clk,
    input  logic   Reset,
    fetch_if.master bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        misalign_q, misalign_d;

    logic [31:0] pc_plus4;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pcplus4;
    logic        ifid_valid;
    logic        redirect;
    pc_sel_e     pc_sel;

    assign pc_plus4 = pc_q + PC_INC;

    // A redirect is only meaningful when ID holds a real instruction.
    assign redirect = (bus.Jump | bus.JumpReg) & ifid_valid;

    always_comb begin
        pc_sel = SEL_SEQ;
        if (redirect && bus.JumpReg) begin
            pc_sel = SEL_JR;
        end else if (redirect) begin
            pc_sel = SEL_JUMP;
        end else if (bus.Stall) begin
            pc_sel = SEL_HOLD;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        fetch_count_d = fetch_count_q;
        misalign_d    = misalign_q;
        case (pc_sel)
            SEL_JR: begin
                pc_d = jr_target(bus.JrTarget);
                if (bus.JrTarget[1:0] != 2'b00) begin
                    misalign_d = 1'b1;
                end
            end
            SEL_JUMP: begin
                pc_d = jump_target(ifid_pcplus4, ifid_instr);
            end
            SEL_HOLD: begin
                pc_d = pc_q;
            end
            default: begin
                pc_d          = pc_plus4;
                fetch_count_d = fetch_count_q + 32'd1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q          <= RESET_PC;
            fetch_count_q <= 32'd0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            misalign_q    <= misalign_d;
        end
    end

    if_id_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id_reg (
        .Clk         (Clk),
        .Reset       (Reset),
        .en          (~bus.Stall),
        .flush       (redirect),
        .instr_in    (bus.ImemData),
        .pc_plus4_in (pc_plus4),
        .instr       (ifid_instr),
        .pc_plus4    (ifid_pcplus4),
        .valid       (ifid_valid)
    );

    assign bus.ImemAddr         = pc_q;
    assign bus.IfId_Instruction = ifid_instr;
    assign bus.IfId_PCPlus4     = ifid_pcplus4;
    assign bus.IfId_Valid       = ifid_valid;
    assign bus.FetchCount       = fetch_count_q;
    assign bus.Misalign         = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run, all compared against a behavioural model of the fetch rules.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic Clk;
    logic Reset;
    fetch_if bus ();

    fetch_stage #(
        .RESET_PC (RPC),
        .NOP_WORD (NOP)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_pc, m_ir, m_pp4, m_cnt;
    logic        m_valid, m_mis;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2008_0000;
    endfunction

    task automatic model_step(input logic rst, input logic stall, input logic jump,
                              input logic jr, input logic [31:0] jrt,
                              input logic [31:0] data);
        logic [31:0] tgt;
        if (rst) begin
            m_pc = RPC; m_ir = NOP; m_pp4 = 0; m_valid = 0; m_cnt = 0; m_mis = 0;
        end else if ((jump || jr) && m_valid) begin
            if (jr) begin
                tgt = jrt & ~32'd3;
                if (jrt % 4 != 0) m_mis = 1'b1;
            end else begin
                tgt = (m_pp4 & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
            end
            m_pc = tgt; m_ir = NOP; m_pp4 = 0; m_valid = 0;
        end else if (!stall) begin
            m_ir = data; m_pp4 = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
            m_pc = m_pc + 4;
        end
        exp_q.push_back(m_ir);
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic rst, input logic stall, input logic jump,
                               input logic jr, input logic [31:0] jrt,
                               input logic [31:0] data);
        Reset        = rst;
        bus.Stall    = stall;
        bus.Jump     = jump;
        bus.JumpReg  = jr;
        bus.JrTarget = jrt;
        bus.ImemData = data;
        @(posedge Clk);
        model_step(rst, stall, jump, jr, jrt, data);
        #1;
    endtask

    task automatic do_reset();
        drive_cycle(1, 0, 0, 0, 0, 32'hDEAD_BEEF);
        drive_cycle(1, 1, 1, 1, 32'h3, 32'hDEAD_BEEF);
        exp_q.delete();
    endtask

    task automatic step(input logic stall, input logic jump, input logic jr,
                        input logic [31:0] jrt);
        drive_cycle(0, stall, jump, jr, jrt, mem_word(m_pc));
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks += 6;
        if (bus.ImemAddr !== RPC) begin errors++; $display("FAIL reset_pc got=%h exp=%h", bus.ImemAddr, RPC); end
        if (bus.IfId_Instruction !== NOP) begin errors++; $display("FAIL reset_ir got=%h exp=%h", bus.IfId_Instruction, NOP); end
        if (bus.IfId_PCPlus4 !== 32'd0) begin errors++; $display("FAIL reset_pp4 got=%h exp=0", bus.IfId_PCPlus4); end
        if (bus.IfId_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.IfId_Valid); end
        if (bus.FetchCount !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.FetchCount); end
        if (bus.Misalign !== 1'b0) begin errors++; $display("FAIL reset_mis got=%b exp=0", bus.Misalign); end
    endtask

    task automatic test_free_run();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            drive_cycle(0, 0, 0, 0, 0, 32'h2008_0005);
            checks += 4;
            if (bus.ImemAddr !== 32'(4 * i)) begin errors++; $display("FAIL run_addr[%0d] got=%h exp=%h", i, bus.ImemAddr, 4 * i); end
            if (bus.IfId_PCPlus4 !== 32'(4 * i)) begin errors++; $display("FAIL run_pp4[%0d] got=%h exp=%h", i, bus.IfId_PCPlus4, 4 * i); end
            if (bus.IfId_Valid !== 1'b1) begin errors++; $display("FAIL run_valid[%0d] got=%b exp=1", i, bus.IfId_Valid); end
            if (bus.IfId_Instruction !== 32'h2008_0005) begin errors++; $display("FAIL run_ir[%0d] got=%h exp=20080005", i, bus.IfId_Instruction); end
        end
        checks++;
        if (bus.FetchCount !== 32'd4) begin errors++; $display("FAIL run_cnt got=%0d exp=4", bus.FetchCount); end
    endtask

    task automatic test_stall();
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0);
            checks += 4;
            if (bus.ImemAddr !== 32'd8) begin errors++; $display("FAIL stall_addr got=%h exp=8", bus.ImemAddr); end
            if (bus.IfId_PCPlus4 !== 32'd8) begin errors++; $display("FAIL stall_pp4 got=%h exp=8", bus.IfId_PCPlus4); end
            if (bus.IfId_Instruction !== mem_word(32'd4)) begin errors++; $display("FAIL stall_ir got=%h exp=%h", bus.IfId_Instruction, mem_word(32'd4)); end
            if (bus.FetchCount !== 32'd2) begin errors++; $display("FAIL stall_cnt got=%0d exp=2", bus.FetchCount); end
        end
        step(0, 0, 0, 0);
        checks += 3;
        if (bus.ImemAddr !== 32'd12) begin errors++; $display("FAIL resume_addr got=%h exp=c", bus.ImemAddr); end
        if (bus.IfId_Instruction !== mem_word(32'd8)) begin errors++; $display("FAIL resume_ir got=%h exp=%h", bus.IfId_Instruction, mem_word(32'd8)); end
        if (bus.FetchCount !== 32'd3) begin errors++; $display("FAIL resume_cnt got=%0d exp=3", bus.FetchCount); end
    endtask

    task automatic test_jump();
        logic [31:0] j_instr;
        j_instr = {OP_J, 26'h10};
        do_reset();
        step(0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, j_instr);
        checks += 2;
        if (bus.IfId_Instruction !== 32'h0800_0010) begin errors++; $display("FAIL j_latch got=%h exp=08000010", bus.IfId_Instruction); end
        if (bus.IfId_PCPlus4 !== 32'd8) begin errors++; $display("FAIL j_pp4 got=%h exp=8", bus.IfId_PCPlus4); end
        step(0, 1, 0, 0);
        checks += 4;
        if (bus.ImemAddr !== 32'h40) begin errors++; $display("FAIL j_target got=%h exp=40", bus.ImemAddr); end
        if (bus.IfId_Valid !== 1'b0) begin errors++; $display("FAIL j_bubble_valid got=%b exp=0", bus.IfId_Valid); end
        if (bus.IfId_Instruction !== NOP) begin errors++; $display("FAIL j_bubble_ir got=%h exp=%h", bus.IfId_Instruction, NOP); end
        if (bus.FetchCount !== 32'd2) begin errors++; $display("FAIL j_cnt got=%0d exp=2", bus.FetchCount); end
        step(0, 0, 0, 0);
        checks += 3;
        if (bus.IfId_Instruction !== mem_word(32'h40)) begin errors++; $display("FAIL j_after_ir got=%h exp=%h", bus.IfId_Instruction, mem_word(32'h40)); end
        if (bus.IfId_PCPlus4 !== 32'h44) begin errors++; $display("FAIL j_after_pp4 got=%h exp=44", bus.IfId_PCPlus4); end
        if (bus.IfId_Valid !== 1'b1) begin errors++; $display("FAIL j_after_valid got=%b exp=1", bus.IfId_Valid); end
    endtask

    task automatic test_jr_misalign();
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0102);
        checks += 2;
        if (bus.ImemAddr !== 32'h100) begin errors++; $display("FAIL jr_target got=%h exp=100", bus.ImemAddr); end
        if (bus.Misalign !== 1'b1) begin errors++; $display("FAIL jr_mis got=%b exp=1", bus.Misalign); end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        checks += 2;
        if (bus.Misalign !== 1'b1) begin errors++; $display("FAIL mis_sticky got=%b exp=1", bus.Misalign); end
        if (bus.ImemAddr !== 32'h10C) begin errors++; $display("FAIL jr_seq got=%h exp=10c", bus.ImemAddr); end
        do_reset();
        checks++;
        if (bus.Misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got=%b exp=0", bus.Misalign); end
        // Jump and JumpReg together: the register target must win.
        drive_cycle(0, 0, 0, 0, 0, {OP_JAL, 26'h20});
        step(0, 1, 1, 32'h0000_0200);
        checks += 2;
        if (bus.ImemAddr !== 32'h200) begin errors++; $display("FAIL jr_wins got=%h exp=200", bus.ImemAddr); end
        if (bus.Misalign !== 1'b0) begin errors++; $display("FAIL jr_aligned_mis got=%b exp=0", bus.Misalign); end
    endtask

    task automatic test_jump_stall();
        do_reset();
        drive_cycle(0, 0, 0, 0, 0, {OP_J, 26'h10});
        step(1, 1, 0, 0);
        checks += 3;
        if (bus.ImemAddr !== 32'h40) begin errors++; $display("FAIL js_target got=%h exp=40", bus.ImemAddr); end
        if (bus.IfId_Valid !== 1'b0) begin errors++; $display("FAIL js_bubble got=%b exp=0", bus.IfId_Valid); end
        if (bus.FetchCount !== 32'd1) begin errors++; $display("FAIL js_cnt got=%0d exp=1", bus.FetchCount); end
        step(0, 1, 0, 0);
        checks += 3;
        if (bus.ImemAddr !== 32'h44) begin errors++; $display("FAIL j_ignored_addr got=%h exp=44", bus.ImemAddr); end
        if (bus.IfId_Valid !== 1'b1) begin errors++; $display("FAIL j_ignored_valid got=%b exp=1", bus.IfId_Valid); end
        if (bus.FetchCount !== 32'd2) begin errors++; $display("FAIL j_ignored_cnt got=%0d exp=2", bus.FetchCount); end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        checks++;
        if (bus.ImemAddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_hold got=%h exp=fffffffc", bus.ImemAddr); end
        drive_cycle(1, 1, 1, 0, 0, 32'h1234_5678);
        checks += 4;
        if (bus.ImemAddr !== RPC) begin errors++; $display("FAIL midreset_pc got=%h exp=%h", bus.ImemAddr, RPC); end
        if (bus.IfId_Valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b exp=0", bus.IfId_Valid); end
        if (bus.FetchCount !== 32'd0) begin errors++; $display("FAIL midreset_cnt got=%0d exp=0", bus.FetchCount); end
        if (bus.IfId_Instruction !== NOP) begin errors++; $display("FAIL midreset_ir got=%h exp=%h", bus.IfId_Instruction, NOP); end
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        checks += 3;
        if (bus.ImemAddr !== 32'd0) begin errors++; $display("FAIL wrap_pc got=%h exp=0", bus.ImemAddr); end
        if (bus.IfId_PCPlus4 !== 32'd0) begin errors++; $display("FAIL wrap_pp4 got=%h exp=0", bus.IfId_PCPlus4); end
        if (bus.IfId_Instruction !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_ir got=%h exp=%h", bus.IfId_Instruction, mem_word(32'hFFFF_FFFC)); end
    endtask

    task automatic test_random();
        logic [31:0] exp_ir;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(0, 63) == 0,
                        $urandom_range(0, 3) == 0,
                        $urandom_range(0, 5) == 0,
                        $urandom_range(0, 7) == 0,
                        $urandom(),
                        $urandom());
            exp_ir = exp_q.pop_front();
            checks += 6;
            if (bus.IfId_Instruction !== exp_ir) begin errors++; $display("FAIL rnd_ir[%0d] got=%h exp=%h", i, bus.IfId_Instruction, exp_ir); end
            if (bus.ImemAddr !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, bus.ImemAddr, m_pc); end
            if (bus.IfId_PCPlus4 !== m_pp4) begin errors++; $display("FAIL rnd_pp4[%0d] got=%h exp=%h", i, bus.IfId_PCPlus4, m_pp4); end
            if (bus.IfId_Valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, bus.IfId_Valid, m_valid); end
            if (bus.FetchCount !== m_cnt) begin errors++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", i, bus.FetchCount, m_cnt); end
            if (bus.Misalign !== m_mis) begin errors++; $display("FAIL rnd_mis[%0d] got=%b exp=%b", i, bus.Misalign, m_mis); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        Reset        = 1'b1;
        bus.Stall    = 1'b0;
        bus.Jump     = 1'b0;
        bus.JumpReg  = 1'b0;
        bus.JrTarget = 32'd0;
        bus.ImemData = 32'd0;
        test_reset();
        test_free_run();
        test_stall();
        test_jump();
        test_jr_misalign();
        test_jump_stall();
        test_wrap_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
